dec_out_collector: RTL and testbench

DEC_OUT_COLLECTOR -- requirements
Module: dec_out_collector

---
 rtl/dec_out_collector_pkg.sv | 15 +
 rtl/dec_out_fifo.sv | 45 ++++
 rtl/dec_out_collector.sv | 131 +++++++++++++
 tb/tb_dec_out_collector.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_out_collector_pkg.sv
// Shared decoder parameters and state encoding for the decoded-beat output collector.
package dec_out_collector_pkg;

  localparam int Zc               = 8;
  localparam int DecOut_lifting   = 1;
  localparam int BlkNumperDecoder = 2;
  localparam int BLK_IDX_W        = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/dec_out_fifo.sv
// Show-ahead synchronous FIFO; the head entry is visible on rdata_o whenever empty_o is low.
module dec_out_fifo #(
  parameter int W     = 13,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // When full, a simultaneous push overwrites the slot being popped, which is safe.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/dec_out_collector.sv
// Frames decoded beats into blocks (sop/eop/block index) and buffers them for a ready/valid sink.
// Optional DEC_OUT_OVF_CNT_EN adds a saturating 16-bit dropped-beat counter output ovf_cnt.
module dec_out_collector
  import dec_out_collector_pkg::*;
#(
  parameter int DW            = Zc*DecOut_lifting,
  parameter int BEATS_PER_BLK = 8,
  parameter int BLK_NUM       = BlkNumperDecoder,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 dec_valid,
  input  logic [BLK_IDX_W-1:0] dec_valid_cnt,
  input  logic [DW-1:0]        dec_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DW-1:0]        m_data,
  output logic                 m_sop,
  output logic                 m_eop,
  output logic [BLK_IDX_W-1:0] m_blk_idx,
  output logic                 ovf,
  output logic                 busy,
  output logic                 all_done
`ifdef DEC_OUT_OVF_CNT_EN
  ,
  output logic [15:0]          ovf_cnt
`endif
);

  localparam int EW  = DW + 2 + BLK_IDX_W;
  localparam int BCW = (BEATS_PER_BLK > 1) ? $clog2(BEATS_PER_BLK) : 1;
  localparam logic [BCW-1:0]       LAST_BEAT = BCW'(BEATS_PER_BLK-1);
  localparam logic [BLK_IDX_W-1:0] LAST_BLK  = BLK_IDX_W'(BLK_NUM-1);

  state_e         state_q, state_d;
  logic [BCW-1:0] beat_cnt_q, beat_cnt_d;
  logic           ovf_q, all_done_q;
  logic           accept, is_sop, is_eop, push, pop, drop;
  logic           fifo_empty, fifo_full;
  logic [EW-1:0]  fifo_wdata, fifo_rdata;

  // Write-side framing: the beat counter advances on every accepted beat, stored or dropped.
  assign accept     = dec_valid && (state_q != DONE) && !clr;
  assign is_sop     = (beat_cnt_q == '0);
  assign is_eop     = (beat_cnt_q == LAST_BEAT);
  assign pop        = m_valid && m_ready && !clr;
  assign push       = accept && (!fifo_full || pop);
  assign drop       = accept && fifo_full && !pop;
  assign fifo_wdata = {dec_valid_cnt, is_sop, is_eop, dec_data};

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE, RECV: begin
        if (dec_valid) begin
          beat_cnt_d = is_eop ? '0 : beat_cnt_q + BCW'(1);
          state_d    = (is_eop && dec_valid_cnt == LAST_BLK) ? DONE : RECV;
        end
      end
      default: ;
    endcase
    if (clr) begin
      state_d    = IDLE;
      beat_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      ovf_q      <= 1'b0;
      all_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      if (clr) begin
        ovf_q      <= 1'b0;
        all_done_q <= 1'b0;
      end else begin
        if (drop) ovf_q <= 1'b1;
        if (pop && m_eop && m_blk_idx == LAST_BLK) all_done_q <= 1'b1;
      end
    end
  end

`ifdef DEC_OUT_OVF_CNT_EN
  logic [15:0] ovf_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt_q <= '0;
    end else if (clr) begin
      ovf_cnt_q <= '0;
    end else if (drop && ovf_cnt_q != 16'hFFFF) begin
      ovf_cnt_q <= ovf_cnt_q + 16'd1;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
`endif

  dec_out_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clr),
    .push_i  (push),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Read side: head fields are forced to zero while empty so reset/clr show a clean bus.
  assign m_valid   = !fifo_empty;
  assign m_data    = m_valid ? fifo_rdata[DW-1:0]          : '0;
  assign m_eop     = m_valid ? fifo_rdata[DW]              : 1'b0;
  assign m_sop     = m_valid ? fifo_rdata[DW+1]            : 1'b0;
  assign m_blk_idx = m_valid ? fifo_rdata[EW-1 -: BLK_IDX_W] : '0;
  assign ovf       = ovf_q;
  assign all_done  = all_done_q;
  assign busy      = (state_q == RECV) || !fifo_empty;

endmodule

// File: tb/tb_dec_out_collector.sv
// Directed testbench for dec_out_collector (DW=8, 8 beats/block, 2 blocks, 16-entry FIFO).
module tb_dec_out_collector;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n, clr, dec_valid, m_ready;
  logic [2:0]    dec_valid_cnt;
  logic [DW-1:0] dec_data;
  logic          m_valid, m_sop, m_eop, ovf, busy, all_done;
  logic [DW-1:0] m_data;
  logic [2:0]    m_blk_idx;
`ifdef DEC_OUT_OVF_CNT_EN
  logic [15:0]   ovf_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dec_out_collector #(
    .DW            (DW),
    .BEATS_PER_BLK (8),
    .BLK_NUM       (2),
    .FIFO_DEPTH    (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr           (clr),
    .dec_valid     (dec_valid),
    .dec_valid_cnt (dec_valid_cnt),
    .dec_data      (dec_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_sop         (m_sop),
    .m_eop         (m_eop),
    .m_blk_idx     (m_blk_idx),
    .ovf           (ovf),
    .busy          (busy),
    .all_done      (all_done)
`ifdef DEC_OUT_OVF_CNT_EN
    ,
    .ovf_cnt       (ovf_cnt)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; clr = 1'b0; dec_valid = 1'b0; dec_valid_cnt = '0;
    dec_data = '0; m_ready = 1'b0;
    tick; tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset;
    rst_n = 1'b0;
    tick;
    tests++;
    if ({m_valid, m_sop, m_eop, m_blk_idx, m_data, ovf, busy, all_done} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %b required all zero",
               {m_valid, m_sop, m_eop, m_blk_idx, m_data, ovf, busy, all_done});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    do_reset;
    m_ready = 1'b1;
    tests++;
    if (m_valid !== 1'b0) begin
      fails++; $display("FAIL basic_empty: m_valid got %b required 0", m_valid);
    end
    for (int i = 0; i < 8; i++) begin
      dec_valid = 1'b1; dec_valid_cnt = 3'd0; dec_data = 8'(i + 1);
      tick;
      tests++;
      if ({m_valid, m_data, m_sop, m_eop, m_blk_idx} !== {1'b1, 8'(i + 1), (i == 0), (i == 7), 3'd0}) begin
        fails++;
        $display("FAIL basic_beat%0d: got v=%b d=%h sop=%b eop=%b blk=%0d required v=1 d=%h sop=%b eop=%b blk=0",
                 i, m_valid, m_data, m_sop, m_eop, m_blk_idx, 8'(i + 1), (i == 0), (i == 7));
      end
    end
    dec_valid = 1'b0;
    tick;
    tests++;
    if ({m_valid, busy} !== 2'b01) begin
      fails++; $display("FAIL basic_drained: got v=%b busy=%b required v=0 busy=1", m_valid, busy);
    end
  endtask

  task automatic test_overflow;
    do_reset;
    for (int k = 1; k <= 20; k++) begin
      dec_valid = 1'b1; dec_valid_cnt = 3'd0; dec_data = 8'(8'h0F + k);
      tick;
      tests++;
      if (ovf !== (k >= 17)) begin
        fails++; $display("FAIL ovf_beat%0d: got %b required %b", k, ovf, (k >= 17));
      end
    end
`ifdef DEC_OUT_OVF_CNT_EN
    tests++;
    if (ovf_cnt !== 16'd4) begin
      fails++; $display("FAIL ovf_cnt: got %0d required 4", ovf_cnt);
    end
`endif
    dec_valid = 1'b0; m_ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      tests++;
      if ({m_valid, m_data, m_eop} !== {1'b1, 8'(8'h10 + j), (j % 8 == 7)}) begin
        fails++;
        $display("FAIL ovf_drain%0d: got v=%b d=%h eop=%b required v=1 d=%h eop=%b",
                 j, m_valid, m_data, m_eop, 8'(8'h10 + j), (j % 8 == 7));
      end
      tick;
    end
    tests++;
    if ({m_valid, ovf} !== 2'b01) begin
      fails++; $display("FAIL ovf_after_drain: got v=%b ovf=%b required v=0 ovf=1", m_valid, ovf);
    end
    for (int k = 0; k < 4; k++) begin
      dec_valid = 1'b1; dec_data = 8'(8'h40 + k);
      tick;
      tests++;
      if ({m_valid, m_data, m_sop, m_eop} !== {1'b1, 8'(8'h40 + k), 1'b0, (k == 3)}) begin
        fails++;
        $display("FAIL ovf_realign%0d: got v=%b d=%h sop=%b eop=%b required v=1 d=%h sop=0 eop=%b",
                 k, m_valid, m_data, m_sop, m_eop, 8'(8'h40 + k), (k == 3));
      end
    end
    dec_valid = 1'b0;
  endtask

  task automatic test_full_push_pop;
    do_reset;
    for (int i = 0; i < 16; i++) begin
      dec_valid = 1'b1; dec_valid_cnt = 3'd0; dec_data = 8'(8'h20 + i);
      tick;
    end
    dec_data = 8'h30; m_ready = 1'b1;
    tick;
    tests++;
    if ({ovf, m_data} !== {1'b0, 8'h21}) begin
      fails++; $display("FAIL full_pushpop: got ovf=%b d=%h required ovf=0 d=21", ovf, m_data);
    end
    m_ready = 1'b0; dec_data = 8'h31;
    tick;
    tests++;
    if (ovf !== 1'b1) begin
      fails++; $display("FAIL full_still_full: ovf got %b required 1", ovf);
    end
    dec_valid = 1'b0; m_ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      tests++;
      if ({m_valid, m_data} !== {1'b1, (j < 15) ? 8'(8'h21 + j) : 8'h30}) begin
        fails++;
        $display("FAIL full_drain%0d: got v=%b d=%h required v=1 d=%h",
                 j, m_valid, m_data, (j < 15) ? 8'(8'h21 + j) : 8'h30);
      end
      tick;
    end
    tests++;
    if (m_valid !== 1'b0) begin
      fails++; $display("FAIL full_empty: m_valid got %b required 0", m_valid);
    end
  endtask

  task automatic test_done;
    do_reset;
    m_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 8; i++) begin
        dec_valid = 1'b1; dec_valid_cnt = 3'(b); dec_data = 8'(8'h80 + b*8 + i);
        tick;
      end
    end
    tests++;
    if ({m_valid, m_eop, m_blk_idx, m_data, all_done, busy} !== {1'b1, 1'b1, 3'd1, 8'h8F, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL done_last_head: got v=%b eop=%b blk=%0d d=%h all_done=%b busy=%b required 1 1 1 8f 0 1",
               m_valid, m_eop, m_blk_idx, m_data, all_done, busy);
    end
    dec_valid_cnt = 3'd1; dec_data = 8'h99;
    tick;
    tests++;
    if ({all_done, m_valid, ovf, busy} !== 4'b1000) begin
      fails++;
      $display("FAIL done_final_pop: got all_done=%b v=%b ovf=%b busy=%b required 1 0 0 0",
               all_done, m_valid, ovf, busy);
    end
    tick;
    tests++;
    if ({all_done, m_valid} !== 2'b10) begin
      fails++; $display("FAIL done_sticky: got all_done=%b v=%b required 1 0", all_done, m_valid);
    end
    dec_valid = 1'b0; clr = 1'b1;
    tick;
    clr = 1'b0;
    tests++;
    if (all_done !== 1'b0) begin
      fails++; $display("FAIL done_clr: all_done got %b required 0", all_done);
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    for (int i = 0; i < 3; i++) begin
      dec_valid = 1'b1; dec_valid_cnt = 3'd0; dec_data = 8'(8'h50 + i);
      tick;
    end
    dec_data = 8'h53;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({m_valid, m_sop, m_eop, m_blk_idx, m_data, ovf, busy, all_done} !== '0) begin
      fails++;
      $display("FAIL midreset_outputs: got %b required all zero",
               {m_valid, m_sop, m_eop, m_blk_idx, m_data, ovf, busy, all_done});
    end
    tick;
    rst_n = 1'b1; dec_data = 8'h55;
    tick;
    dec_valid = 1'b0;
    tests++;
    if ({m_valid, m_sop, m_data} !== {1'b1, 1'b1, 8'h55}) begin
      fails++;
      $display("FAIL midreset_sop: got v=%b sop=%b d=%h required v=1 sop=1 d=55", m_valid, m_sop, m_data);
    end
  endtask

  task automatic test_clr;
    do_reset;
    for (int k = 0; k < 20; k++) begin
      dec_valid = 1'b1; dec_valid_cnt = 3'd0; dec_data = 8'(8'h60 + k);
      tick;
    end
    tests++;
    if ({m_valid, ovf} !== 2'b11) begin
      fails++; $display("FAIL clr_pre: got v=%b ovf=%b required 1 1", m_valid, ovf);
    end
    clr = 1'b1; m_ready = 1'b1;
    tick;
    clr = 1'b0; dec_valid = 1'b0;
    tests++;
    if ({m_valid, ovf, all_done, busy} !== 4'b0000) begin
      fails++;
      $display("FAIL clr_state: got v=%b ovf=%b all_done=%b busy=%b required 0 0 0 0",
               m_valid, ovf, all_done, busy);
    end
`ifdef DEC_OUT_OVF_CNT_EN
    tests++;
    if (ovf_cnt !== 16'd0) begin
      fails++; $display("FAIL clr_ovf_cnt: got %0d required 0", ovf_cnt);
    end
`endif
    dec_valid = 1'b1; dec_data = 8'h66;
    tick;
    dec_valid = 1'b0;
    tests++;
    if ({m_valid, m_sop, m_data} !== {1'b1, 1'b1, 8'h66}) begin
      fails++;
      $display("FAIL clr_restart: got v=%b sop=%b d=%h required v=1 sop=1 d=66", m_valid, m_sop, m_data);
    end
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; dec_valid = 1'b0; dec_valid_cnt = '0;
    dec_data = '0; m_ready = 1'b0;
    test_reset;
    test_basic;
    test_overflow;
    test_full_push_pop;
    test_done;
    test_reset_mid;
    test_clr;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
